game_flow_ctrl: RTL and testbench

Frame-synchronous game-flow controller for the dino game. It owns the game state (title, play, dying, game over) and debounces the four direction buttons plus debug. It latches dino/obstacle collisions seen during scan-out and drives halt/restart to the movement, asteroid and score blocks. All state changes are committed only at frame boundaries so the display never tears mid-frame.

---
 rtl/game_pkg.sv | 16 +
 rtl/game_flow_ctrl_debounce.sv | 43 ++++
 rtl/game_flow_ctrl.sv | 126 ++++++++++++
 tb/tb_game_flow_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings and default timing constants for the dino game-flow controller.
package game_pkg;

    localparam int STATE_W             = 2;
    localparam int DEATH_CNT_W         = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int DEATH_FRAMES_DEF    = 60;

    typedef enum logic [STATE_W-1:0] {
        ST_TITLE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2,
        ST_DYING = 2'd3
    } game_state_t;

endpackage

// File: rtl/game_flow_ctrl_debounce.sv
// Two-flop synchronizer plus hold-time debouncer for one raw button or switch.
import game_pkg::*;

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-synchronous game-state FSM: debounced inputs, collision latch, death timer.
import game_pkg::*;

module game_flow_ctrl #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DEATH_FRAMES    = DEATH_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               leftbtn,
    input  logic               rightbtn,
    input  logic               upbtn,
    input  logic               downbtn,
    input  logic               debug,
    input  logic               frame_start,
    input  logic               pixel_collide,
    output logic [STATE_W-1:0] game_state,
    output logic               halt,
    output logic               restart,
    output logic               death_sel,
    output logic [3:0]         btn_level
);

    localparam logic [DEATH_CNT_W-1:0] DEATH_INIT = DEATH_CNT_W'(DEATH_FRAMES - 1);

    logic [4:0]             w_raw;
    logic [4:0]             w_lvl;
    logic [3:0]             w_btn;
    logic                   w_debug;
    logic                   w_press;
    logic                   w_eff_press;
    logic                   w_eff_coll;
    game_state_t            w_next;
    logic [DEATH_CNT_W-1:0] w_next_cnt;
    logic                   w_restart_nxt;

    game_state_t            r_state;
    logic [DEATH_CNT_W-1:0] r_death_cnt;
    logic [3:0]             r_btn_prev;
    logic                   r_press_pend;
    logic                   r_coll_seen;
    logic                   r_halt;
    logic                   r_restart;
    logic                   r_death_sel;

    assign w_raw = {leftbtn, rightbtn, upbtn, downbtn, debug};

    for (genvar g = 0; g < 5; g++) begin : g_deb
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (w_raw[g]),
            .o_level (w_lvl[g])
        );
    end

    assign w_btn       = w_lvl[4:1];
    assign w_debug     = w_lvl[0];
    assign w_press     = |(w_btn & ~r_btn_prev);
    assign w_eff_press = r_press_pend | w_press;
    assign w_eff_coll  = r_coll_seen | (pixel_collide && (r_state == ST_PLAY));

    // Debug overrides everything and returns to TITLE without a restart pulse.
    always_comb begin
        w_next        = r_state;
        w_next_cnt    = r_death_cnt;
        w_restart_nxt = 1'b0;
        if (frame_start) begin
            if (w_debug) begin
                w_next = ST_TITLE;
            end else begin
                case (r_state)
                    ST_TITLE, ST_OVER: begin
                        if (w_eff_press) begin
                            w_next        = ST_PLAY;
                            w_restart_nxt = 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        if (w_eff_coll) begin
                            w_next     = ST_DYING;
                            w_next_cnt = DEATH_INIT;
                        end
                    end
                    ST_DYING: begin
                        if (r_death_cnt == '0) w_next = ST_OVER;
                        else                   w_next_cnt = r_death_cnt - DEATH_CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_TITLE;
            r_death_cnt  <= '0;
            r_btn_prev   <= '0;
            r_press_pend <= 1'b0;
            r_coll_seen  <= 1'b0;
            r_halt       <= 1'b1;
            r_restart    <= 1'b0;
            r_death_sel  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_death_cnt <= w_next_cnt;
            r_btn_prev  <= w_btn;
            r_restart   <= w_restart_nxt;
            r_halt      <= (w_next != ST_PLAY);
            r_death_sel <= (w_next == ST_DYING) || (w_next == ST_OVER);
            // Latches only span one frame; the frame edge consumes and clears them.
            if (frame_start)  r_press_pend <= 1'b0;
            else if (w_press) r_press_pend <= 1'b1;
            if (frame_start)                                 r_coll_seen <= 1'b0;
            else if (pixel_collide && (r_state == ST_PLAY)) r_coll_seen <= 1'b1;
        end
    end

    assign game_state = r_state;
    assign halt       = r_halt;
    assign restart    = r_restart;
    assign death_sel  = r_death_sel;
    assign btn_level  = w_btn;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scoreboard bench for game_flow_ctrl (DEBOUNCE_CYCLES=4, DEATH_FRAMES=3).
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_drv = 4'b0;
    logic       debug = 1'b0;
    logic       frame_start = 1'b0;
    logic       pixel_collide = 1'b0;
    logic [1:0] game_state;
    logic       halt, restart, death_sel;
    logic [3:0] btn_level;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int         at;
        string      name;
        logic [1:0] st;
        logic       halt;
        logic       rst;
        logic       ds;
        logic [3:0] btn;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    game_flow_ctrl #(.DEBOUNCE_CYCLES(4), .DEATH_FRAMES(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .leftbtn       (btn_drv[3]),
        .rightbtn      (btn_drv[2]),
        .upbtn         (btn_drv[1]),
        .downbtn       (btn_drv[0]),
        .debug         (debug),
        .frame_start   (frame_start),
        .pixel_collide (pixel_collide),
        .game_state    (game_state),
        .halt          (halt),
        .restart       (restart),
        .death_sel     (death_sel),
        .btn_level     (btn_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    a_fs_single: assert property (@(posedge clk) disable iff (reset) frame_start |=> !frame_start);

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            m_e = q.pop_front();
            n_checks++;
            if (m_e.at < cyc)
                $display("FAIL %s: sample for cycle %0d missed (now %0d)", m_e.name, m_e.at, cyc);
            else if ({game_state, halt, restart, death_sel, btn_level} !==
                     {m_e.st, m_e.halt, m_e.rst, m_e.ds, m_e.btn})
                $display("FAIL %s: got st=%0d halt=%b restart=%b death_sel=%b btn=%b, expected st=%0d halt=%b restart=%b death_sel=%b btn=%b",
                         m_e.name, game_state, halt, restart, death_sel, btn_level,
                         m_e.st, m_e.halt, m_e.rst, m_e.ds, m_e.btn);
            else
                n_pass++;
        end
    end

    task automatic expect_at(input int d, input string nm, input logic [1:0] st,
                             input logic h, input logic r, input logic ds, input logic [3:0] b);
        exp_t e;
        e.at = cyc + d; e.name = nm; e.st = st; e.halt = h; e.rst = r; e.ds = ds; e.btn = b;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic press_btn(input logic [3:0] b);
        btn_drv = b;
        step(8);
        btn_drv = 4'b0;
        step(8);
    endtask

    task automatic collide_pulse();
        pixel_collide = 1'b1;
        step(1);
        pixel_collide = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        step(3);
        reset = 1'b0;
        expect_at(0, "reset_release", 2'd0, 1, 0, 0, 4'b0000);

        // short up pulse is filtered
        step(2);
        btn_drv = 4'b0010;
        step(3);
        btn_drv = 4'b0000;
        step(6);
        expect_at(0, "short_pulse", 2'd0, 1, 0, 0, 4'b0000);

        // held up: level follows 2+4 cycles after the edge, then start game
        btn_drv = 4'b0010;
        expect_at(5, "deb_before", 2'd0, 1, 0, 0, 4'b0000);
        expect_at(6, "deb_after", 2'd0, 1, 0, 0, 4'b0010);
        step(8);
        frame();
        expect_at(0, "title_to_play", 2'd1, 0, 1, 0, 4'b0010);
        step(1);
        expect_at(0, "restart_one_cycle", 2'd1, 0, 0, 0, 4'b0010);
        btn_drv = 4'b0000;
        step(10);
        expect_at(0, "up_released", 2'd1, 0, 0, 0, 4'b0000);

        // mid-frame collision, DYING for three frames then OVER
        collide_pulse();
        step(5);
        expect_at(0, "coll_not_yet", 2'd1, 0, 0, 0, 4'b0000);
        frame();
        expect_at(0, "play_to_dying", 2'd3, 1, 0, 1, 4'b0000);
        step(3); frame();
        expect_at(0, "dying_f1", 2'd3, 1, 0, 1, 4'b0000);
        step(3); frame();
        expect_at(0, "dying_f2", 2'd3, 1, 0, 1, 4'b0000);
        step(3); frame();
        expect_at(0, "dying_to_over", 2'd2, 1, 0, 1, 4'b0000);

        // collision outside PLAY is ignored; right press restarts
        step(2);
        collide_pulse();
        step(2);
        press_btn(4'b0100);
        frame();
        expect_at(0, "over_to_play", 2'd1, 0, 1, 0, 4'b0000);
        step(1);
        expect_at(0, "restart_drop", 2'd1, 0, 0, 0, 4'b0000);
        step(3); frame();
        expect_at(0, "no_stale_coll", 2'd1, 0, 0, 0, 4'b0000);

        // collision in the frame_start cycle; press during DYING is discarded
        step(3);
        pixel_collide = 1'b1;
        frame_start = 1'b1;
        step(1);
        pixel_collide = 1'b0;
        frame_start = 1'b0;
        expect_at(0, "same_cycle_coll", 2'd3, 1, 0, 1, 4'b0000);
        press_btn(4'b0001);
        frame();
        expect_at(0, "dying_press_f1", 2'd3, 1, 0, 1, 4'b0000);
        step(3); frame();
        expect_at(0, "dying_press_f2", 2'd3, 1, 0, 1, 4'b0000);
        step(3); frame();
        expect_at(0, "dying_press_over", 2'd2, 1, 0, 1, 4'b0000);
        step(3); frame();
        expect_at(0, "press_discarded", 2'd2, 1, 0, 1, 4'b0000);

        // left press and debug before the same frame: debug wins
        step(2);
        btn_drv = 4'b1000;
        debug = 1'b1;
        step(8);
        frame();
        expect_at(0, "debug_wins", 2'd0, 1, 0, 0, 4'b1000);
        step(1);
        expect_at(0, "debug_no_restart", 2'd0, 1, 0, 0, 4'b1000);
        btn_drv = 4'b0000;
        debug = 1'b0;
        step(10);
        expect_at(0, "debug_released", 2'd0, 1, 0, 0, 4'b0000);

        // async reset in the middle of DYING
        press_btn(4'b0010);
        frame();
        expect_at(0, "replay", 2'd1, 0, 1, 0, 4'b0000);
        step(2);
        collide_pulse();
        step(2);
        frame();
        expect_at(0, "redying", 2'd3, 1, 0, 1, 4'b0000);
        step(2);
        reset = 1'b1;
        expect_at(0, "reset_async", 2'd0, 1, 0, 0, 4'b0000);
        step(3);
        expect_at(0, "reset_hold", 2'd0, 1, 0, 0, 4'b0000);
        reset = 1'b0;
        step(1);
        expect_at(0, "reset_no_restart", 2'd0, 1, 0, 0, 4'b0000);
        step(2); frame();
        expect_at(0, "title_idle", 2'd0, 1, 0, 0, 4'b0000);

        step(3);
        while (q.size() > 0) begin
            m_e = q.pop_front();
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d never sampled", m_e.name, m_e.at);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
